// File: rtl/uart_tx_feeder_if.sv
// Host-side FIFO push port and UART transmit handshake for the byte feeder.
// The feeder is the slave; the host/UART environment is the master.
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              clr_ovf;
  logic              enable;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;

  modport slave (
    input  wr_en, wr_data, clr_ovf, enable, tx_busy,
    output full, empty, level, overflow, tx_start, tx_data, tx_done
  );

  modport master (
    output wr_en, wr_data, clr_ovf, enable, tx_busy,
    input  full, empty, level, overflow, tx_start, tx_data, tx_done
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Buffered byte source for the UART transmitter: host bytes queue in a FIFO
// and are launched one at a time with a single-cycle tx_start pulse.
module uart_tx_feeder #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_feeder_if.slave    bus
);

  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [7:0]          r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wrPtr;
  logic [ADDR_W-1:0]   r_rdPtr;
  logic [ADDR_W:0]     r_level;
  logic [ADDR_W:0]     w_levelNext;
  logic                r_full;
  logic                r_empty;
  logic                r_overflow;
  logic                r_txStart;
  logic [7:0]          r_txData;
  logic                r_txDone;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;

  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign w_push = bus.wr_en && !r_full;
  assign w_drop = bus.wr_en && r_full;
  assign w_pop  = (r_state == IDLE) && bus.enable && !r_empty && !bus.tx_busy;

  always_comb begin
    w_levelNext = r_level;
    if (w_push && !w_pop) begin
      w_levelNext = r_level + 1'b1;
    end else if (w_pop && !w_push) begin
      w_levelNext = r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_txStart  <= 1'b0;
      r_txData   <= 8'h00;
      r_txDone   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr  <= r_rdPtr + 1'b1;
        r_txData <= r_mem[r_rdPtr];
      end
      r_level <= w_levelNext;
      r_full  <= (w_levelNext == LEVEL_FULL);
      r_empty <= (w_levelNext == '0);
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_overflow <= 1'b0;
      end
      r_txStart <= w_pop;
      r_txDone  <= (r_state == WAIT_DONE) && !bus.tx_busy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:      if (w_pop) w_nextState = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy) w_nextState = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  assign bus.full     = r_full;
  assign bus.empty    = r_empty;
  assign bus.level    = r_level;
  assign bus.overflow = r_overflow;
  assign bus.tx_start = r_txStart;
  assign bus.tx_data  = r_txData;
  assign bus.tx_done  = r_txDone;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder driving a 16x-oversampled 8N1 UART model
// with a serial receiver that reconstructs each transmitted byte.
module tb_uart_tx_feeder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.ADDR_W(3)) bus ();

  uart_tx_feeder #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic       uBusy;
  logic [9:0] uShift;
  logic [3:0] uCnt;
  logic [3:0] uBit;
  logic [7:0] uLatched;
  logic       txLine;

  // UART transmitter: 10 bits of 16 clocks each, start bit first, LSB first.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      uBusy    <= 1'b0;
      uShift   <= 10'h3FF;
      uCnt     <= '0;
      uBit     <= '0;
      uLatched <= 8'h00;
    end else if (!uBusy) begin
      if (bus.tx_start) begin
        uShift   <= {1'b1, bus.tx_data, 1'b0};
        uLatched <= bus.tx_data;
        uBusy    <= 1'b1;
        uCnt     <= '0;
        uBit     <= '0;
      end
    end else if (uCnt == 4'd15) begin
      uCnt   <= '0;
      uShift <= {1'b1, uShift[9:1]};
      if (uBit == 4'd9) uBusy <= 1'b0;
      else              uBit  <= uBit + 1'b1;
    end else begin
      uCnt <= uCnt + 1'b1;
    end
  end

  assign txLine      = uBusy ? uShift[0] : 1'b1;
  assign bus.tx_busy = uBusy;

  logic [7:0] startLog[$];
  logic [7:0] rxLog[$];
  int  doneCount      = 0;
  int  doubleStart    = 0;
  int  startWhileBusy = 0;
  int  dataUnstable   = 0;
  bit  prevStart      = 0;

  // Handshake monitor, sampled between rising edges.
  always @(negedge clk) begin
    if (rst) begin
      prevStart = 0;
    end else begin
      if (bus.tx_start) begin
        startLog.push_back(bus.tx_data);
        if (prevStart) doubleStart++;
        if (bus.tx_busy) startWhileBusy++;
      end
      prevStart = bus.tx_start;
      if (bus.tx_done) doneCount++;
      if (uBusy && bus.tx_data !== uLatched) dataUnstable++;
    end
  end

  logic [7:0] rxByte;
  bit         rxAbort;

  always begin
    @(negedge clk);
    if (!rst && txLine == 1'b0) begin
      rxAbort = 0;
      repeat (8) begin @(negedge clk); rxAbort |= rst; end
      if (txLine !== 1'b0) rxAbort = 1;
      for (int i = 0; i < 8; i++) begin
        repeat (16) begin @(negedge clk); rxAbort |= rst; end
        rxByte[i] = txLine;
      end
      repeat (16) begin @(negedge clk); rxAbort |= rst; end
      if (txLine !== 1'b1) rxAbort = 1;
      if (!rxAbort) rxLog.push_back(rxByte);
    end
  end

  task automatic pushByte(input logic [7:0] b);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
  endtask

  task automatic pushEnd();
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic waitBusy(input logic val, input int budget, output bit ok);
    int n = 0;
    @(negedge clk);
    while (bus.tx_busy !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.tx_busy === val);
  endtask

  task automatic waitDones(input int target, input int budget, output bit ok);
    int n = 0;
    while (doneCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (doneCount >= target);
  endtask

  function automatic logic [7:0] logAt(input logic [7:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 8'hxx;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
    total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    total++; if (bus.tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done: got %b want 0", bus.tx_done); end
  endtask

  task automatic test_single();
    int d0 = doneCount;
    int s0 = startLog.size();
    int r0 = rxLog.size();
    bit ok;
    bus.enable = 1'b1;
    pushByte(8'hA5);
    pushEnd();
    waitBusy(1'b1, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_busy_rise: got timeout want busy=1"); end
    waitBusy(1'b0, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_busy_fall: got timeout want busy=0"); end
    @(negedge clk);
    total++; if (bus.tx_done !== 1'b1) begin bad++; $display("FAIL single_done_pulse: got %b want 1", bus.tx_done); end
    @(negedge clk);
    total++; if (bus.tx_done !== 1'b0) begin bad++; $display("FAIL single_done_width: got %b want 0", bus.tx_done); end
    repeat (4) @(negedge clk);
    total++; if (doneCount - d0 != 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", doneCount - d0); end
    total++; if (startLog.size() - s0 != 1) begin bad++; $display("FAIL single_start_count: got %0d want 1", startLog.size() - s0); end
    total++; if (logAt(startLog, s0) !== 8'hA5) begin bad++; $display("FAIL single_tx_data: got %h want a5", logAt(startLog, s0)); end
    total++; if (logAt(rxLog, r0) !== 8'hA5) begin bad++; $display("FAIL single_serial: got %h want a5", logAt(rxLog, r0)); end
    total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL single_level: got %0d want 0", bus.level); end
    total++; if (doubleStart != 0) begin bad++; $display("FAIL single_start_width: got %0d want 0", doubleStart); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    int d0 = doneCount;
    int s0 = startLog.size();
    int r0 = rxLog.size();
    int gap = 0;
    bit ok;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    pushByte(8'h11);
    pushByte(8'h22);
    pushByte(8'h33);
    pushEnd();
    waitBusy(1'b1, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_busy_rise: got timeout want busy=1"); end
    waitBusy(1'b0, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_busy_fall: got timeout want busy=0"); end
    while (bus.tx_start !== 1'b1 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    total++; if (gap != 2) begin bad++; $display("FAIL b2b_gap: got %0d cycles want 2", gap); end
    waitDones(d0 + 3, 1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_done_timeout: got %0d dones want 3", doneCount - d0); end
    repeat (20) @(negedge clk);
    total++; if (doneCount - d0 != 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", doneCount - d0); end
    for (int i = 0; i < 3; i++) begin
      total++; if (logAt(startLog, s0 + i) !== exp[i]) begin bad++; $display("FAIL b2b_tx_data[%0d]: got %h want %h", i, logAt(startLog, s0 + i), exp[i]); end
      total++; if (logAt(rxLog, r0 + i) !== exp[i]) begin bad++; $display("FAIL b2b_serial[%0d]: got %h want %h", i, logAt(rxLog, r0 + i), exp[i]); end
    end
    total++; if (startWhileBusy != 0) begin bad++; $display("FAIL b2b_start_while_busy: got %0d want 0", startWhileBusy); end
    total++; if (dataUnstable != 0) begin bad++; $display("FAIL b2b_data_stable: got %0d want 0", dataUnstable); end
  endtask

  task automatic test_overflow();
    int d0, s0, r0;
    bit ok;
    bus.enable = 1'b0;
    d0 = doneCount; s0 = startLog.size(); r0 = rxLog.size();
    for (int i = 0; i < 8; i++) pushByte(8'(i));
    pushByte(8'hFF);
    pushEnd();
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", bus.full); end
    total++; if (bus.level !== 4'd8) begin bad++; $display("FAIL ovf_level: got %0d want 8", bus.level); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", bus.empty); end
    bus.enable = 1'b1;
    waitDones(d0 + 8, 2500, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_done_timeout: got %0d dones want 8", doneCount - d0); end
    repeat (30) @(negedge clk);
    total++; if (startLog.size() - s0 != 8) begin bad++; $display("FAIL ovf_start_count: got %0d want 8", startLog.size() - s0); end
    for (int i = 0; i < 8; i++) begin
      total++; if (logAt(startLog, s0 + i) !== 8'(i)) begin bad++; $display("FAIL ovf_tx_data[%0d]: got %h want %h", i, logAt(startLog, s0 + i), 8'(i)); end
      total++; if (logAt(rxLog, r0 + i) !== 8'(i)) begin bad++; $display("FAIL ovf_serial[%0d]: got %h want %h", i, logAt(rxLog, r0 + i), 8'(i)); end
    end
    total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL ovf_level_drained: got %0d want 0", bus.level); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    @(negedge clk); bus.clr_ovf = 1'b1;
    @(negedge clk); bus.clr_ovf = 1'b0;
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
  endtask

  task automatic test_enable_drop();
    int d0, s0, r0;
    bit ok;
    bus.enable = 1'b0;
    d0 = doneCount; s0 = startLog.size(); r0 = rxLog.size();
    pushByte(8'h3C);
    pushByte(8'hC3);
    pushEnd();
    bus.enable = 1'b1;
    waitBusy(1'b1, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL endrop_busy_rise: got timeout want busy=1"); end
    @(negedge clk);
    @(negedge clk);
    bus.enable = 1'b0;
    waitDones(d0 + 1, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL endrop_first_done: got %0d dones want 1", doneCount - d0); end
    repeat (50) @(negedge clk);
    total++; if (doneCount - d0 != 1) begin bad++; $display("FAIL endrop_held_done: got %0d want 1", doneCount - d0); end
    total++; if (startLog.size() - s0 != 1) begin bad++; $display("FAIL endrop_held_start: got %0d want 1", startLog.size() - s0); end
    total++; if (logAt(startLog, s0) !== 8'h3C) begin bad++; $display("FAIL endrop_first_data: got %h want 3c", logAt(startLog, s0)); end
    total++; if (bus.level !== 4'd1) begin bad++; $display("FAIL endrop_level: got %0d want 1", bus.level); end
    bus.enable = 1'b1;
    waitDones(d0 + 2, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL endrop_second_done: got %0d dones want 2", doneCount - d0); end
    repeat (10) @(negedge clk);
    total++; if (logAt(startLog, s0 + 1) !== 8'hC3) begin bad++; $display("FAIL endrop_second_data: got %h want c3", logAt(startLog, s0 + 1)); end
    total++; if (logAt(rxLog, r0 + 1) !== 8'hC3) begin bad++; $display("FAIL endrop_second_serial: got %h want c3", logAt(rxLog, r0 + 1)); end
    total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL endrop_level_final: got %0d want 0", bus.level); end
  endtask

  task automatic test_reset_midframe();
    int d0, s0, r0;
    bit ok;
    bus.enable = 1'b0;
    pushByte(8'h81);
    pushByte(8'h82);
    pushByte(8'h83);
    pushByte(8'h84);
    pushEnd();
    bus.enable = 1'b1;
    waitBusy(1'b1, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_busy_rise: got timeout want busy=1"); end
    repeat (20) @(negedge clk);
    d0 = doneCount; s0 = startLog.size(); r0 = rxLog.size();
    rst = 1'b1;
    #1;
    total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL rstmid_level: got %0d want 0", bus.level); end
    total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL rstmid_tx_start: got %b want 0", bus.tx_start); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty: got %b want 1", bus.empty); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    total++; if (doneCount != d0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", doneCount - d0); end
    total++; if (startLog.size() != s0) begin bad++; $display("FAIL rstmid_no_start: got %0d want 0", startLog.size() - s0); end
    pushByte(8'h5A);
    pushEnd();
    waitDones(d0 + 1, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_next_done: got %0d dones want 1", doneCount - d0); end
    repeat (10) @(negedge clk);
    total++; if (logAt(startLog, s0) !== 8'h5A) begin bad++; $display("FAIL rstmid_next_data: got %h want 5a", logAt(startLog, s0)); end
    total++; if (logAt(rxLog, r0) !== 8'h5A) begin bad++; $display("FAIL rstmid_next_serial: got %h want 5a", logAt(rxLog, r0)); end
    total++; if (rxLog.size() - r0 != 1) begin bad++; $display("FAIL rstmid_rx_count: got %0d want 1", rxLog.size() - r0); end
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    bus.enable  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_enable_drop();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish before 100000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
